int_ctrl: RTL

- Multi-source interrupt controller for the 8-bit computer. It replaces the single UART int_req path with an arbitrated, maskable scheme.
- Collects edge events from NUM_SRC peripherals (UART RX, UART TX done, timer, ...) and latches them as pending.
- Picks the highest-priority enabled event, raises a one-cycle int_req to the cpu, latches the return address, and blocks further dispatch until the handler writes end-of-interrupt (EOI).
- Memory-mapped on the data bus (rs_data as address, rd_data as write data); its read data is muxed ahead of data_mem.

---
 rtl/int_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Multi-source interrupt controller: edge-detected, maskable, fixed-priority
// dispatch to the cpu with a memory-mapped register block and EOI handshake.
module int_ctrl #(
   parameter int         NUM_SRC   = 4,
   parameter logic [7:0] ADDR_VEC  = 8'd250,
   parameter logic [7:0] ADDR_RET  = 8'd251,
   parameter logic [7:0] ADDR_MASK = 8'd249,
   parameter logic [7:0] ADDR_STAT = 8'd248,
   parameter logic [7:0] ADDR_EOI  = 8'd247
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [7:0]         addr,
   input  logic [7:0]         w_data,
   input  logic               w_en,
   output logic [7:0]         r_data,
   output logic               r_hit,
   input  logic [7:0]         cpu_ret_addr,
   output logic               int_req,
   output logic [7:0]         int_en,
   output logic [7:0]         int_vec
);

   typedef enum logic {IDLE, SERVICE} state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] prev_q, prev_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [7:0]         vec_q, vec_d;
   logic [7:0]         ret_q, ret_d;
   logic [7:0]         mask_q, mask_d;
   logic               act_valid_q, act_valid_d;
   logic [2:0]         act_id_q, act_id_d;

   logic [NUM_SRC-1:0] rise, elig, win_oh, w1c, clr;
   logic [2:0]         win_id;
   logic               dispatch;
   logic [3:0]         pend4;

   generate
      if (NUM_SRC >= 4) begin : g_stat_wide
         assign pend4 = pend_q[3:0];
      end else begin : g_stat_narrow
         assign pend4 = {{(4-NUM_SRC){1'b0}}, pend_q};
      end
   endgenerate

   always_comb begin
      rise = irq_src & ~prev_q;
      elig = mask_q[7] ? (pend_q & mask_q[NUM_SRC-1:0]) : '0;
      win_oh = '0;
      win_id = '0;
      // Scan high to low so the lowest eligible index is left standing.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_id    = 3'(i);
         end
      end
      dispatch = (state_q == IDLE) && (elig != '0);

      w1c    = (w_en && addr == ADDR_STAT) ? w_data[NUM_SRC-1:0] : '0;
      clr    = w1c | (dispatch ? win_oh : '0);
      pend_d = (pend_q & ~clr) | rise;
      prev_d = irq_src;

      vec_d  = (w_en && addr == ADDR_VEC)  ? w_data : vec_q;
      mask_d = (w_en && addr == ADDR_MASK) ? w_data : mask_q;

      state_d     = state_q;
      ret_d       = ret_q;
      act_valid_d = act_valid_q;
      act_id_d    = act_id_q;
      if (state_q == IDLE) begin
         if (dispatch) begin
            state_d     = SERVICE;
            ret_d       = cpu_ret_addr;
            act_valid_d = 1'b1;
            act_id_d    = win_id;
         end
      end else if (w_en && addr == ADDR_EOI) begin
         state_d     = IDLE;
         act_valid_d = 1'b0;
         act_id_d    = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         pend_q      <= '0;
         vec_q       <= '0;
         ret_q       <= '0;
         mask_q      <= '0;
         act_valid_q <= 1'b0;
         act_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         pend_q      <= pend_d;
         vec_q       <= vec_d;
         ret_q       <= ret_d;
         mask_q      <= mask_d;
         act_valid_q <= act_valid_d;
         act_id_q    <= act_id_d;
      end
   end

   assign int_req = dispatch;
   assign int_en  = {7'b0, state_q == IDLE};
   assign int_vec = vec_q;

   always_comb begin
      r_hit  = 1'b1;
      r_data = 8'h00;
      case (addr)
         ADDR_VEC:  r_data = vec_q;
         ADDR_RET:  r_data = ret_q;
         ADDR_MASK: r_data = mask_q;
         ADDR_STAT: r_data = {act_valid_q, act_id_q, pend4};
         ADDR_EOI:  r_data = 8'h00;
         default:   r_hit  = 1'b0;
      endcase
   end

endmodule
